// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding load/store bus master for the valid/ready memory interface
module mem_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic        we, uns;
  logic [1:0]  size, ofs;
  logic        bad, expire;
  logic [3:0]  strb;
  logic [31:0] wdat, shifted, ld_data;
  // request decode, lane steering and load extension
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    strb = !req_we ? 4'b0000 : req_size == 2'b00 ? 4'b0001 << req_addr[1:0] : req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    wdat = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    shifted = mem_rdata >> {ofs, 3'b000};
    ld_data = we ? 32'd0 : size == 2'b00 ? {{24{~uns & shifted[7]}}, shifted[7:0]} : size == 2'b01 ? {{16{~uns & shifted[15]}}, shifted[15:0]} : shifted;
    expire = TIMEOUT_CYCLES != 0 && {1'b0, cnt} + 9'd1 == 9'(TIMEOUT_CYCLES);
  end
  // transaction FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cnt <= '0;
      we <= 1'b0;
      uns <= 1'b0;
      size <= '0;
      ofs <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we <= req_we;
          uns <= req_unsigned;
          size <= req_size;
          ofs <= req_addr[1:0];
          mem_addr <= {req_addr[31:2], 2'b00};
          mem_wdata <= wdat;
          mem_wstrb <= strb;
          req_ready <= 1'b0;
          cnt <= '0;
          if (bad) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= BUS;
            mem_valid <= 1'b1;
          end
        end
        BUS: if (mem_ready || expire) begin
          state <= RESP;
          mem_valid <= 1'b0;
          resp_valid <= 1'b1;
          resp_err <= !mem_ready;
          resp_rdata <= mem_ready ? ld_data : 32'd0;
          cnt <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          resp_rdata <= '0;
          req_ready <= 1'b1;
          cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed vector bench for mem_initiator against a latency-programmable BRAM model
module tb_mem_initiator;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_valid;
  logic        mem_ready = 0;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  logic [31:0] ram [64];
  int          lat = 4;
  int          vcnt = 0;
  int          n_vec = 0;
  int          fails = 0;

  mem_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // responder: ready on the lat-th cycle of mem_valid (lat=0 never answers)
  always @(negedge clk) begin
    if (!mem_valid) begin
      vcnt = 0;
      mem_ready = 0;
    end else begin
      mem_ready = lat != 0 && vcnt == lat - 1;
      vcnt = vcnt + 1;
    end
    mem_rdata = ram[mem_addr[7:2]];
  end

  always @(posedge clk)
    if (mem_valid && mem_ready)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [31:0] mwdata;
    int          busc;
    int          respc;
  } vec_t;

  vec_t v [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", n_vec, nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int c = 1, busc = 0;
    logic [31:0] a0 = 0, w0 = 0;
    logic [3:0] s0 = 0;
    logic unstable = 0;
    n_vec++;
    lat = t.lat;
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk); #1;
    req_valid = 0;
    while (!resp_valid && c < 60) begin
      if (mem_valid) begin
        if (busc == 0) begin a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; end
        else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wstrb !== s0) unstable = 1;
        busc++;
      end
      @(posedge clk); #1;
      c++;
    end
    chk("resp_cycle", c, t.respc);
    chk("bus_cycles", busc, t.busc);
    chk("resp_err", {31'd0, resp_err}, {31'd0, t.err});
    chk("resp_rdata", resp_rdata, t.rdata);
    chk("mem_valid_at_resp", {31'd0, mem_valid}, 32'd0);
    if (t.busc > 0) begin
      chk("mem_addr", a0, {t.addr[31:2], 2'b00});
      chk("mem_wstrb", {28'd0, s0}, {28'd0, t.wstrb});
      chk("mem_wdata", w0, t.mwdata);
      chk("bus_stable", {31'd0, unstable}, 32'd0);
    end
    @(posedge clk); #1;
    chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 64; i++) ram[i] = 0;
    ram[32] = 32'h876543A1;
    //         we    size   uns   addr         wdata         lat err rdata         wstrb    mwdata        busc respc
    v[0]  = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        4,  1'b0, 32'h876543A1, 4'b0000, 32'h0,        4,  5};
    v[1]  = '{1'b0, 2'b00, 1'b0, 32'h83, 32'h0,        4,  1'b0, 32'hFFFFFF87, 4'b0000, 32'h0,        4,  5};
    v[2]  = '{1'b0, 2'b00, 1'b1, 32'h81, 32'h0,        4,  1'b0, 32'h00000043, 4'b0000, 32'h0,        4,  5};
    v[3]  = '{1'b0, 2'b01, 1'b0, 32'h82, 32'h0,        4,  1'b0, 32'hFFFF8765, 4'b0000, 32'h0,        4,  5};
    v[4]  = '{1'b0, 2'b01, 1'b1, 32'h80, 32'h0,        4,  1'b0, 32'h000043A1, 4'b0000, 32'h0,        4,  5};
    v[5]  = '{1'b1, 2'b00, 1'b0, 32'h82, 32'h000000AB, 4,  1'b0, 32'h0,        4'b0100, 32'hABABABAB, 4,  5};
    v[6]  = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        4,  1'b0, 32'h87AB43A1, 4'b0000, 32'h0,        4,  5};
    v[7]  = '{1'b1, 2'b10, 1'b0, 32'h84, 32'hDEADBEEF, 4,  1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 4,  5};
    v[8]  = '{1'b0, 2'b10, 1'b0, 32'h84, 32'h0,        4,  1'b0, 32'hDEADBEEF, 4'b0000, 32'h0,        4,  5};
    v[9]  = '{1'b1, 2'b01, 1'b0, 32'h86, 32'h00001234, 4,  1'b0, 32'h0,        4'b1100, 32'h12341234, 4,  5};
    v[10] = '{1'b0, 2'b01, 1'b0, 32'h84, 32'h0,        4,  1'b0, 32'hFFFFBEEF, 4'b0000, 32'h0,        4,  5};
    v[11] = '{1'b0, 2'b01, 1'b1, 32'h86, 32'h0,        4,  1'b0, 32'h00001234, 4'b0000, 32'h0,        4,  5};
    v[12] = '{1'b0, 2'b10, 1'b0, 32'h82, 32'h0,        4,  1'b1, 32'h0,        4'b0000, 32'h0,        0,  1};
    v[13] = '{1'b0, 2'b01, 1'b0, 32'h81, 32'h0,        4,  1'b1, 32'h0,        4'b0000, 32'h0,        0,  1};
    v[14] = '{1'b0, 2'b11, 1'b0, 32'h80, 32'h0,        4,  1'b1, 32'h0,        4'b0000, 32'h0,        0,  1};
    v[15] = '{1'b1, 2'b10, 1'b0, 32'h81, 32'h11223344, 4,  1'b1, 32'h0,        4'b0000, 32'h0,        0,  1};
    v[16] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        16, 17};
    v[17] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        16, 1'b0, 32'h87AB43A1, 4'b0000, 32'h0,        16, 17};
    v[18] = '{1'b0, 2'b00, 1'b0, 32'h80, 32'h0,        1,  1'b0, 32'hFFFFFFA1, 4'b0000, 32'h0,        1,  2};
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    n_vec++;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    for (int i = 0; i < 19; i++) run_vec(v[i]);
    n_vec++;
    lat = 4;
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 0;
    chk("abort_bus_started", {31'd0, mem_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid || mem_valid) seen = 1;
    end
    chk("abort_no_activity", {31'd0, seen}, 32'd0);
    run_vec(v[6]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
    $finish;
  end
endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-master (initiator) side of the native valid/ready memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) used by the on-chip BRAM controller.
- Accepts one load/store request at a time from the CPU core, then generates word address, byte strobes and lane-replicated write data.
- Holds the bus until the responder raises mem_ready, extracts and sign/zero-extends load data, and returns a single-cycle response.
- Flags misaligned accesses, and aborts transactions whose responder does not answer within a bounded time.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_valid stays high without mem_ready before the transaction is aborted. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  block can accept a request (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned/illegal access or timeout; valid with resp_valid
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completion
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_rdata  in  32  responder read data, valid while mem_ready=1

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State IDLE, timeout counter 0.
- Reset asserted in any state, including mid-transaction: mem_valid=0 and resp_valid=0 after that edge. The pending request is discarded with no response.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register the request.
  - Legal and aligned request: go to BUS.
  - Illegal or misaligned request: go to RESP with err=1. No bus cycle is issued.
- BUS:
  - mem_valid=1. mem_addr, mem_wdata and mem_wstrb are registered and stay stable until exit.
  - mem_ready=1 sampled: capture mem_rdata, go to RESP with err=0.
  - Otherwise the counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES (i.e. after TIMEOUT_CYCLES cycles with mem_valid high), go to RESP with err=1 and rdata=0.
  - mem_ready in the same cycle as timeout expiry: mem_ready wins, err=0.
- RESP: resp_valid=1 for exactly one cycle, mem_valid=0, then return to IDLE. The counter clears.
- req_valid is ignored outside IDLE (req_ready=0).
- mem_ready outside BUS is ignored.
- Misaligned/illegal conditions:
  - req_size=11: always illegal.
  - Halfword with addr[0]=1: misaligned.
  - Word with addr[1:0]!=00: misaligned.
- Store strobes and data:
  - Byte: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Halfword: wstrb = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 1111, wdata unchanged.
- Load extraction: shifted = mem_rdata >> (8*addr[1:0]).
  - Byte: extend shifted[7:0].
  - Halfword: extend shifted[15:0].
  - Word: shifted.
  - Sign vs zero extension is selected by req_unsigned.
- Latency against the 4-cycle BRAM responder (request accepted in cycle 0):
  - mem_valid high in cycles 1-4.
  - mem_ready in cycle 4.
  - resp_valid in cycle 5.
  - req_ready high again in cycle 6.
- Latency for a misaligned request: resp_valid in cycle 1.

Test Plan:
- Preload word 0x80 = 0x876543A1. LW 0x80 -> mem_addr=0x80, wstrb=0000, mem_valid high 4 cycles, resp_valid in cycle 5, rdata=0x876543A1, err=0.
- Load extension on the same word:
  - LB 0x83 -> 0xFFFFFF87
  - LBU 0x81 -> 0x00000043
  - LH 0x82 -> 0xFFFF8765
  - LHU 0x80 -> 0x000043A1
- Stores:
  - SB 0x82, wdata 0x000000AB -> mem_addr=0x80, wstrb=0100, mem_wdata=0xABABABAB, resp rdata=0.
  - SW 0x84, 0xDEADBEEF -> wstrb=1111.
- Misaligned and illegal:
  - LW 0x82 -> resp_valid in cycle 1, err=1, mem_valid never asserted.
  - LH 0x81 -> same as LW 0x82.
  - req_size=11 -> err=1.
- Timeout: responder never readies, TIMEOUT_CYCLES=16 -> mem_valid high exactly 16 cycles, resp_err=1, rdata=0, req_ready returns. Ready in the 16th cycle -> err=0.
- Reset asserted in cycle 2 of an LW -> mem_valid=0, resp_valid=0, req_ready=1 after the edge. A following LW completes normally.
